// File: rtl/prefix_adder_pkg.sv
// Shared constants, FSM state encodings and helpers for the prefix adder scheduler.
package prefix_adder_pkg;

  localparam int WORD_W = 16;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_RESP = 2'd2;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prefix_adder_rr_scheduler_rr_picker.sv
// Combinational round-robin picker: first valid requester at or after ptr, wrapping.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx
);

  logic found;
  int   cand;

  // NOTE: every output gets a default before the search so no path leaves a latch.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!found && valid[cand]) begin
        grant[cand] = 1'b1;
        idx         = IDX_W'(cand);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prefix_adder_rr_scheduler.sv
// Round-robin scheduler sharing one external combinational 16-bit adder between requesters.
// Optional multi-word carry chaining is enabled with `define PREFIX_ADDER_CHAIN_EN.
module prefix_adder_rr_scheduler
  import prefix_adder_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*WORD_W-1:0] req_a,
  input  logic [NUM_REQ*WORD_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]        req_cin,
  output logic [WORD_W-1:0]         add_a,
  output logic [WORD_W-1:0]         add_b,
  output logic                      add_cin,
  input  logic [WORD_W-1:0]         add_sum,
  input  logic                      add_cout,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [ID_W-1:0]           rsp_id,
  output logic [WORD_W-1:0]         rsp_sum,
  output logic                      rsp_cout,
  output logic                      busy
`ifdef PREFIX_ADDER_CHAIN_EN
  ,
  input  logic [NUM_REQ-1:0]        req_chain
`endif
);

  state_t               state;
  logic [ID_W-1:0]      rr_ptr;
  logic [ID_W-1:0]      owner;
  logic [NUM_REQ-1:0]   pick_grant;
  logic [ID_W-1:0]      pick_idx;
  logic [ID_W-1:0]      next_ptr;
  logic                 grant_en;
  logic                 granted;
  logic                 sel_cin;

  rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (ID_W)
  ) u_picker (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  // A slot opens when idle, or when the held response is consumed this cycle.
  assign grant_en  = !rst && ((state == S_IDLE) || ((state == S_RESP) && rsp_ready));
  assign req_ready = grant_en ? pick_grant : '0;
  assign granted   = |req_ready;
  assign next_ptr  = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);

`ifdef PREFIX_ADDER_CHAIN_EN
  logic [NUM_REQ-1:0] carry_q;

  assign sel_cin = req_chain[pick_idx] ? carry_q[pick_idx] : req_cin[pick_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= '0;
    end else if (state == S_CALC) begin
      carry_q[owner] <= add_cout;
    end
  end
`else
  assign sel_cin = req_cin[pick_idx];
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      rr_ptr   <= '0;
      owner    <= '0;
      add_a    <= '0;
      add_b    <= '0;
      add_cin  <= 1'b0;
      rsp_id   <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
    end else begin
      case (state)
        S_IDLE: ;
        S_CALC: begin
          rsp_sum  <= add_sum;
          rsp_cout <= add_cout;
          rsp_id   <= owner;
          state    <= S_RESP;
        end
        S_RESP: if (rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      // A grant overrides the return to idle so handshake and new issue share a cycle.
      if (granted) begin
        add_a   <= req_a[WORD_W*pick_idx +: WORD_W];
        add_b   <= req_b[WORD_W*pick_idx +: WORD_W];
        add_cin <= sel_cin;
        owner   <= pick_idx;
        rr_ptr  <= next_ptr;
        state   <= S_CALC;
      end
    end
  end

endmodule

// File: tb/tb_prefix_adder_rr_scheduler.sv
// Directed self-checking bench for prefix_adder_rr_scheduler with an exact adder on add_*.
module tb_prefix_adder_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_ready, req_cin, req_chain;
  logic [63:0] req_a, req_b;
  logic [15:0] add_a, add_b, add_sum, rsp_sum;
  logic        add_cin, add_cout, rsp_valid, rsp_ready, rsp_cout, busy;
  logic [1:0]  rsp_id;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_sum} = 17'(add_a) + 17'(add_b) + 17'(add_cin);

  prefix_adder_rr_scheduler #(.NUM_REQ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_cin   (req_cin),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .busy      (busy)
`ifdef PREFIX_ADDER_CHAIN_EN
    ,
    .req_chain (req_chain)
`endif
  );

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic chain);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_cin[i]        = cin;
    req_chain[i]      = chain;
  endtask

  // Issues one request, waits for its response; returns what was observed.
  task automatic do_op(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic chain,
                       output logic [15:0] sum, output logic cout,
                       output logic [1:0] id, output int lat);
    int n;
    @(negedge clk);
    set_req(i, a, b, cin, chain);
    req_valid[i] = 1'b1;
    #1;
    n = 0;
    while (!req_ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[i]) begin
      tests++;
      fails++;
      $display("FAIL grant_timeout req%0d: req_ready=%b, bit %0d required", i, req_ready, i);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[i] = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    sum  = rsp_sum;
    cout = rsp_cout;
    id   = rsp_id;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 4'b1111;
    repeat (2) @(negedge clk);
    tests++;
    if (req_ready !== 4'b0000) begin
      fails++; $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    tests++;
    if ({add_a, add_b, add_cin} !== 33'd0 || busy !== 1'b0) begin
      fails++; $display("FAIL reset_add: add_a=%h add_b=%h cin=%b busy=%b want all 0",
                        add_a, add_b, add_cin, busy);
    end
    tests++;
    if ({rsp_valid, rsp_sum, rsp_cout, rsp_id} !== 20'd0) begin
      fails++; $display("FAIL reset_rsp: valid=%b sum=%h cout=%b id=%0d want all 0",
                        rsp_valid, rsp_sum, rsp_cout, rsp_id);
    end
    req_valid = 4'b0000;
    rst = 1'b0;
  endtask

  task automatic test_single;
    logic [15:0] s; logic c; logic [1:0] id; int lat;
    do_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, s, c, id, lat);
    tests++;
    if (lat != 1) begin
      fails++; $display("FAIL single_latency: rsp_valid after %0d extra cycles, want 1", lat);
    end
    tests++;
    if (s !== 16'h0100 || c !== 1'b0 || id !== 2'd0) begin
      fails++; $display("FAIL single_result: sum=%h cout=%b id=%0d want 0100/0/0", s, c, id);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || add_a !== 16'h00FF || add_b !== 16'h0001) begin
      fails++; $display("FAIL single_hold: busy=%b add_a=%h add_b=%h want 0/00ff/0001",
                        busy, add_a, add_b);
    end
  endtask

  task automatic test_carry;
    logic [15:0] s; logic c; logic [1:0] id; int lat;
    do_op(3, 16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, id, lat);
    tests++;
    if (s !== 16'h0000 || c !== 1'b1 || id !== 2'd3) begin
      fails++; $display("FAIL carry_wrap: sum=%h cout=%b id=%0d want 0000/1/3", s, c, id);
    end
    do_op(3, 16'h7FFF, 16'h0000, 1'b1, 1'b0, s, c, id, lat);
    tests++;
    if (s !== 16'h8000 || c !== 1'b0 || id !== 2'd3 || add_cin !== 1'b1) begin
      fails++; $display("FAIL carry_cin: sum=%h cout=%b id=%0d add_cin=%b want 8000/0/3/1",
                        s, c, id, add_cin);
    end
    do_op(3, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, s, c, id, lat);
    tests++;
    if (s !== 16'hFFFF || c !== 1'b1) begin
      fails++; $display("FAIL carry_max: sum=%h cout=%b want ffff/1", s, c);
    end
  endtask

  task automatic test_round_robin;
    logic [1:0] order [6];
    int g;
    order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    g = 0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) set_req(k, 16'(16'h1000 * k), 16'(k), 1'b0, 1'b0);
    req_valid = 4'b1111;
    #1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (req_ready !== 4'b0000) begin
        tests++;
        if (g >= 6) begin
          fails++; $display("FAIL rr_extra: grant %b at cycle %0d beyond 6 grants", req_ready, cyc);
        end else begin
          if (req_ready !== (4'b0001 << order[g]) || cyc != 2 * g) begin
            fails++; $display("FAIL rr_order: grant %b at cycle %0d want %b at cycle %0d",
                              req_ready, cyc, 4'b0001 << order[g], 2 * g);
          end
          if (g > 0) begin
            tests++;
            if (!rsp_valid || rsp_id !== order[g-1] ||
                rsp_sum !== 16'(16'h1001 * order[g-1])) begin
              fails++; $display("FAIL rr_rsp: valid=%b id=%0d sum=%h want 1/%0d/%h", rsp_valid,
                                rsp_id, rsp_sum, order[g-1], 16'(16'h1001 * order[g-1]));
            end
          end
        end
        g++;
      end
    end
    tests++;
    if (g != 6) begin
      fails++; $display("FAIL rr_count: %0d grants in 12 cycles, want 6", g);
    end
    @(negedge clk);
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(2, 16'h1234, 16'h1111, 1'b0, 1'b0);
    req_valid = 4'b0100;
    #1;
    tests++;
    if (req_ready !== 4'b0100) begin
      fails++; $display("FAIL bp_first_grant: got %b want 0100", req_ready);
    end
    @(negedge clk);
    set_req(0, 16'h8000, 16'h8000, 1'b0, 1'b0);
    set_req(3, 16'hAAAA, 16'h5555, 1'b1, 1'b0);
    req_valid = 4'b1001;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 16'h2345 || rsp_id !== 2'd2 ||
          rsp_cout !== 1'b0 || req_ready !== 4'b0000) begin
        fails++; $display("FAIL bp_hold[%0d]: valid=%b sum=%h id=%0d cout=%b ready=%b want 1/2345/2/0/0000",
                          k, rsp_valid, rsp_sum, rsp_id, rsp_cout, req_ready);
      end
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    tests++;
    if (req_ready !== 4'b1000) begin
      fails++; $display("FAIL bp_release_grant: got %b want 1000", req_ready);
    end
    @(negedge clk);
    req_valid[3] = 1'b0;
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_sum !== 16'h0000 || rsp_cout !== 1'b1 ||
        req_ready !== 4'b0001) begin
      fails++; $display("FAIL bp_next: valid=%b id=%0d sum=%h cout=%b ready=%b want 1/3/0000/1/0001",
                        rsp_valid, rsp_id, rsp_sum, rsp_cout, req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 16'h0000 || rsp_cout !== 1'b1) begin
      fails++; $display("FAIL bp_last: valid=%b id=%0d sum=%h cout=%b want 1/0/0000/1",
                        rsp_valid, rsp_id, rsp_sum, rsp_cout);
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    set_req(2, 16'h0001, 16'h0001, 1'b0, 1'b0);
    req_valid = 4'b0100;
    @(negedge clk);
    tests++;
    if (busy !== 1'b1) begin
      fails++; $display("FAIL mid_busy: got %b want 1", busy);
    end
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    tests++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || add_a !== 16'h0000 || req_ready !== 4'b0000) begin
      fails++; $display("FAIL mid_reset: busy=%b rsp_valid=%b add_a=%h ready=%b want 0/0/0000/0000",
                        busy, rsp_valid, add_a, req_ready);
    end
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin
      fails++; $display("FAIL mid_held: rsp_valid=%b ready=%b want 0/0000", rsp_valid, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 4'b0001) begin
      fails++; $display("FAIL mid_first: got %b want 0001", req_ready);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 16'h0000 || rsp_cout !== 1'b1) begin
      fails++; $display("FAIL mid_rsp: valid=%b id=%0d sum=%h cout=%b want 1/0/0000/1",
                        rsp_valid, rsp_id, rsp_sum, rsp_cout);
    end
  endtask

`ifdef PREFIX_ADDER_CHAIN_EN
  task automatic test_chain;
    logic [15:0] s; logic c; logic [1:0] id; int lat;
    do_op(2, 16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, id, lat);
    tests++;
    if (s !== 16'h0000 || c !== 1'b1) begin
      fails++; $display("FAIL chain_lsw: sum=%h cout=%b want 0000/1", s, c);
    end
    do_op(1, 16'h0000, 16'h0000, 1'b1, 1'b1, s, c, id, lat);
    tests++;
    if (s !== 16'h0000 || id !== 2'd1) begin
      fails++; $display("FAIL chain_other: sum=%h id=%0d want 0000/1", s, id);
    end
    do_op(2, 16'h0000, 16'h0000, 1'b0, 1'b1, s, c, id, lat);
    tests++;
    if (s !== 16'h0001 || c !== 1'b0 || id !== 2'd2) begin
      fails++; $display("FAIL chain_msw: sum=%h cout=%b id=%0d want 0001/0/2", s, c, id);
    end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;
    req_chain = '0;
    rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_carry();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
`ifdef PREFIX_ADDER_CHAIN_EN
    test_chain();
`endif
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
